// File: rtl/iir_pkg.sv
// Shared definitions for the multi-channel first-order IIR filter: coefficient
// select encodings, width helpers and the saturation bound helper.
package iir_pkg;

    typedef enum logic [1:0] {
        COEF_B0   = 2'd0,
        COEF_B1   = 2'd1,
        COEF_A1   = 2'd2,
        COEF_NONE = 2'd3
    } coef_sel_e;

    function automatic int chw_f(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    function automatic int yw_f(input int dw, input int cw);
        return dw + cw;
    endfunction

    // Largest or smallest two's-complement value of width w, sign-extended to 64 bits.
    function automatic logic [63:0] sat_f(input logic neg, input int w);
        logic [63:0] max_v;
        max_v = (64'd1 << (w - 1)) - 64'd1;
        return neg ? ~max_v : max_v;
    endfunction

endpackage

// File: rtl/iir_first_order_mc_if.sv
// Sample, clear, coefficient and result signals of iir_first_order_mc.
interface iir_first_order_mc_if
    import iir_pkg::*;
#(
    parameter int DW  = 4,
    parameter int CW  = 4,
    parameter int NCH = 2
) ();
    localparam int CHW = chw_f(NCH);
    localparam int YW  = yw_f(DW, CW);

    logic                  in_valid;
    logic [CHW-1:0]        in_ch;
    logic signed [DW-1:0]  x;
    logic                  clr_valid;
    logic [CHW-1:0]        clr_ch;
    logic                  coef_wr;
    logic [1:0]            coef_sel;
    logic signed [CW-1:0]  coef_data;
    logic                  coef_commit;
    logic                  out_valid;
    logic [CHW-1:0]        out_ch;
    logic signed [YW-1:0]  y;
    logic                  ovf;

    modport master (
        output in_valid, in_ch, x, clr_valid, clr_ch,
               coef_wr, coef_sel, coef_data, coef_commit,
        input  out_valid, out_ch, y, ovf
    );

    modport slave (
        input  in_valid, in_ch, x, clr_valid, clr_ch,
               coef_wr, coef_sel, coef_data, coef_commit,
        output out_valid, out_ch, y, ovf
    );
endinterface

// File: rtl/iir_mac.sv
// Combinational IIR datapath: full-precision products, floor-shifted feedback,
// YW+2 bit sum and reduction to YW (wrap, or saturate when IIR_SAT_EN is defined).
module iir_mac
    import iir_pkg::*;
#(
    parameter int DW   = 4,
    parameter int CW   = 4,
    parameter int FRAC = 4,
    parameter int YW   = yw_f(DW, CW)
) (
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] x_prev,
    input  logic signed [YW-1:0] y_prev,
    input  logic signed [CW-1:0] b0,
    input  logic signed [CW-1:0] b1,
    input  logic signed [CW-1:0] a1,
    output logic signed [YW-1:0] y_out,
    output logic                 ovf
);
    localparam int SW = YW + 2;
    localparam int PW = YW + CW;

    logic signed [YW-1:0] p0_s;
    logic signed [YW-1:0] p1_s;
    logic signed [PW-1:0] pf_s;
    logic signed [PW-1:0] pfs_s;
    logic signed [SW-1:0] sum_s;
    logic                 unused_ok_s;

    assign p0_s  = $signed({{CW{x[DW-1]}}, x}) * $signed({{DW{b0[CW-1]}}, b0});
    assign p1_s  = $signed({{CW{x_prev[DW-1]}}, x_prev}) * $signed({{DW{b1[CW-1]}}, b1});
    assign pf_s  = $signed({{CW{y_prev[YW-1]}}, y_prev}) * $signed({{YW{a1[CW-1]}}, a1});
    assign pfs_s = pf_s >>> FRAC;

    // Feedback magnitude after the shift always fits the YW+2 bit accumulator.
    assign sum_s = $signed({{2{p0_s[YW-1]}}, p0_s})
                 + $signed({{2{p1_s[YW-1]}}, p1_s})
                 + $signed(pfs_s[SW-1:0]);

    assign ovf = (sum_s[SW-1:YW-1] != {3{sum_s[SW-1]}});

`ifdef IIR_SAT_EN
    logic [63:0] sat_s;
    assign sat_s       = sat_f(sum_s[SW-1], YW);
    assign y_out       = ovf ? $signed(sat_s[YW-1:0]) : $signed(sum_s[YW-1:0]);
    assign unused_ok_s = ^{pfs_s[PW-1:SW], sat_s[63:YW]};
`else
    assign y_out       = $signed(sum_s[YW-1:0]);
    assign unused_ok_s = ^{pfs_s[PW-1:SW]};
`endif

endmodule

// File: rtl/iir_first_order_mc.sv
// Multi-channel first-order IIR filter top: per-channel state, double-buffered
// coefficients and registered result. Optional saturation via IIR_SAT_EN.
module iir_first_order_mc
    import iir_pkg::*;
#(
    parameter int DW   = 4,
    parameter int CW   = 4,
    parameter int FRAC = 4,
    parameter int NCH  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    iir_first_order_mc_if.slave bus
);
    localparam int CHW   = chw_f(NCH);
    localparam int YW    = yw_f(DW, CW);
    localparam int NSLOT = 1 << CHW;
    localparam logic [CHW:0] NCH_W = (CHW + 1)'(NCH);

    logic signed [DW-1:0] x_st_r [NSLOT];
    logic signed [YW-1:0] y_st_r [NSLOT];
    logic signed [CW-1:0] b0_sh_r, b1_sh_r, a1_sh_r;
    logic signed [CW-1:0] b0_act_r, b1_act_r, a1_act_r;
    logic                 out_valid_r;
    logic [CHW-1:0]       out_ch_r;
    logic signed [YW-1:0] y_r;
    logic                 ovf_r;

    logic                 accept_s;
    logic                 clr_hit_s;
    logic signed [DW-1:0] x_cur_s;
    logic signed [YW-1:0] y_cur_s;
    logic signed [YW-1:0] mac_y_s;
    logic                 mac_ovf_s;

    assign accept_s  = bus.in_valid && ({1'b0, bus.in_ch} < NCH_W);
    assign clr_hit_s = bus.clr_valid && (bus.clr_ch == bus.in_ch);

    // A clear aimed at the sampled channel is seen by that sample as zero state.
    always_comb begin
        x_cur_s = x_st_r[bus.in_ch];
        y_cur_s = y_st_r[bus.in_ch];
        if (clr_hit_s) begin
            x_cur_s = {DW{1'b0}};
            y_cur_s = {YW{1'b0}};
        end else begin
            x_cur_s = x_st_r[bus.in_ch];
            y_cur_s = y_st_r[bus.in_ch];
        end
    end

    iir_mac #(.DW(DW), .CW(CW), .FRAC(FRAC), .YW(YW)) u_mac (
        .x      (bus.x),
        .x_prev (x_cur_s),
        .y_prev (y_cur_s),
        .b0     (b0_act_r),
        .b1     (b1_act_r),
        .a1     (a1_act_r),
        .y_out  (mac_y_s),
        .ovf    (mac_ovf_s)
    );

    // Per-channel state: clear first, then an accepted sample overwrites its channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                x_st_r[i] <= {DW{1'b0}};
                y_st_r[i] <= {YW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (bus.clr_valid && (bus.clr_ch == CHW'(i))) begin
                    x_st_r[i] <= {DW{1'b0}};
                    y_st_r[i] <= {YW{1'b0}};
                end
            end
            if (accept_s) begin
                x_st_r[bus.in_ch] <= bus.x;
                y_st_r[bus.in_ch] <= mac_y_s;
            end
        end
    end

    // Shadow writes and commit; nonblocking commit takes the pre-write shadow value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0_sh_r  <= {CW{1'b0}};
            b1_sh_r  <= {CW{1'b0}};
            a1_sh_r  <= {CW{1'b0}};
            b0_act_r <= {CW{1'b0}};
            b1_act_r <= {CW{1'b0}};
            a1_act_r <= {CW{1'b0}};
        end else begin
            if (bus.coef_wr) begin
                case (coef_sel_e'(bus.coef_sel))
                    COEF_B0: b0_sh_r <= bus.coef_data;
                    COEF_B1: b1_sh_r <= bus.coef_data;
                    COEF_A1: a1_sh_r <= bus.coef_data;
                    default: ;
                endcase
            end
            if (bus.coef_commit) begin
                b0_act_r <= b0_sh_r;
                b1_act_r <= b1_sh_r;
                a1_act_r <= a1_sh_r;
            end
        end
    end

    // Result register; out_valid pulses once per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= {CHW{1'b0}};
            y_r         <= {YW{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_ch_r <= bus.in_ch;
                y_r      <= mac_y_s;
                ovf_r    <= mac_ovf_s;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.y         = y_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: doc/iir_first_order_mc.md
# iir_first_order_mc

Parametrised, multi-channel first-order IIR filter computing y[n] = b0·x[n] + b1·x[n-1] + ((a1·y[n-1]) >>> FRAC) per channel. Channels are time-multiplexed through one datapath with per-channel state registers. Coefficients use double-buffered shadow/active registers with an atomic commit. The block sits in the sample-processing chain between the sample source and downstream consumers, handshaking via valid strobes.

## Interface
- DW, 4: input sample width, signed
- CW, 4: coefficient width, signed
- FRAC, 4: fractional bits of a1; feedback product shifted right by FRAC
- NCH, 2: channel count, ≥1; CHW = max(1, $clog2(NCH))
- YW, DW+CW: output/state width, signed (derived, not overridden)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  sample strobe
- in_ch  in  CHW  channel of sample
- x  in  DW  signed sample
- clr_valid  in  1  clear state of clr_ch
- clr_ch  in  CHW  channel to clear
- coef_wr  in  1  write coef_data to shadow register coef_sel
- coef_sel  in  2  0=b0, 1=b1, 2=a1, 3=ignored
- coef_data  in  CW  signed coefficient
- coef_commit  in  1  copy all shadows to active
- out_valid  out  1  result strobe
- out_ch  out  CHW  channel of result
- y  out  YW  signed result
- ovf  out  1  result overflowed YW (valid with out_valid)

## Operation
- Per channel c: x_state[c] (DW), y_state[c] (YW); all zero at reset.
- Accepted sample (in_valid, in_ch < NCH): compute with active coefficients and state of in_ch; register y/out_ch/ovf, set out_valid; x_state[in_ch] ← x, y_state[in_ch] ← registered y.
- in_ch ≥ NCH: sample dropped, no out_valid, no state change.
- Arithmetic: products full precision (DW+CW, YW+CW); feedback = (y_state·a1) >>> FRAC (arithmetic, floor toward −∞); sum in YW+2 bits; reduce to YW per configuration; ovf=1 when sum lies outside YW range.
- clr_valid: x_state/y_state[clr_ch] ← 0. Same cycle, same channel as in_valid: clear applies first; sample computes with zero state and its result is stored.
- coef_wr updates shadow only. coef_commit: active ← shadow at the edge; a sample accepted in that cycle uses old active values. coef_wr and coef_commit in same cycle: commit takes the pre-write shadow value.
- Reset values: out_valid 0, out_ch 0, y 0, ovf 0; all shadow/active coefficients 0.
- No back-pressure: every cycle may carry a sample, including back-to-back on the same channel.

## Timing
- Latency 1: sample at edge k → out_valid/y at k+1; out_valid high exactly one cycle per accepted sample.
- Same-channel back-to-back samples use the just-updated state (no bubble).
- Reset asserted mid-stream: outputs, state and coefficients clear asynchronously; first sample after release sees zero state.

## Configuration
- IIR_SAT_EN defined: overflowing sums saturate to max/min YW value.
- Undefined: two's-complement wrap (keep low YW bits). ovf asserted in both modes.

## Structure
- Package iir_pkg: coef_sel encodings (COEF_B0, COEF_B1, COEF_A1), CHW/YW width helper functions, saturate function.
- Sub-module iir_mac: combinational datapath (products, shift, sum, wrap/saturate, ovf); top holds state, coefficient registers and output register.

## Test plan
- b0=2, b1=0, a1=0 committed; x=3 ch0 → next cycle y=6, out_ch=0, ovf=0.
- b0=1, a1=8; impulse x=4 then zeros ch0 → y=4,2,1,0.
- b0=1, a1=8; x=−1 then zeros → y=−1,−1,−1 (floor shift).
- b0=b1=a1=7; x=7 ×3 ch0 → y=49,119, then 150: wrap −106 or with IIR_SAT_EN 127, ovf=1.
- Interleave ch0 impulse 4 / ch1 x=0 with b0=1, a1=8 → ch0 decays 4,2,1; ch1 stays 0; clr on ch0 mid-decay → next ch0 zero-input y=0.
- coef_wr b0=3 without commit, x=1 → y=old b0; commit with simultaneous x=1 → old b0; next x=1 → 3.
